// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding instruction-memory
// read at a time and delivers fetched words into the IF/ID register.
module fetch_stage #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              redirect,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready
);

  typedef enum logic [2:0] {
    BOOT,
    ISSUE,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] id_pc_q;
  logic [31:0]       id_instr_q;
  logic [31:0]       hold_q;
  logic              id_valid_q;
  logic              req_q;

  logic slot_free;
  logic resp_owed;

  assign slot_free = !id_valid_q || id_ready;

  // A redirect must still absorb a response that memory has already committed to.
  assign resp_owed = ((state_q == WAIT)  && !imem_rvalid) ||
                     ((state_q == ISSUE) &&  imem_gnt)    ||
                     ((state_q == DROP)  && !imem_rvalid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      hold_q     <= '0;
      req_q      <= 1'b0;
    end else begin
      if (id_valid_q && id_ready) begin
        id_valid_q <= 1'b0;
      end

      if (redirect) begin
        pc_q       <= pc_next;
        id_valid_q <= 1'b0;
        hold_q     <= '0;
        state_q    <= resp_owed ? DROP : ISSUE;
        req_q      <= !resp_owed;
      end else begin
        case (state_q)
          BOOT: begin
            state_q <= ISSUE;
            req_q   <= 1'b1;
          end
          ISSUE: begin
            if (imem_gnt) begin
              state_q <= WAIT;
              req_q   <= 1'b0;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              if (slot_free) begin
                id_valid_q <= 1'b1;
                id_instr_q <= imem_rdata;
                id_pc_q    <= pc_q;
                pc_q       <= pc_next;
                state_q    <= ISSUE;
                req_q      <= 1'b1;
              end else begin
                hold_q  <= imem_rdata;
                state_q <= HOLD;
              end
            end
          end
          HOLD: begin
            if (slot_free) begin
              id_valid_q <= 1'b1;
              id_instr_q <= hold_q;
              id_pc_q    <= pc_q;
              pc_q       <= pc_next;
              state_q    <= ISSUE;
              req_q      <= 1'b1;
            end
          end
          DROP: begin
            if (imem_rvalid) begin
              state_q <= ISSUE;
              req_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= BOOT;
            req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = req_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level model of fetch/deliver/flush
// predicts every output each cycle while a responder plays instruction memory.
module tb_fetch_stage;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next = '0;
  logic          redirect = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [AW-1:0] id_pc;
  logic          id_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_next(pc_next), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of what the fetch stage owes: a request to make, a response to await
  // (possibly to be thrown away), a word parked for decode, and the IF/ID contents.
  logic [31:0] m_pc, m_instr, m_idpc, m_hold;
  bit m_idv, m_req, m_owed, m_discard, m_buffered, m_boot;

  bit          busy;
  int          cnt;
  logic [31:0] raddr;
  int          lat_fix;
  bit          spurious;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_idpc = '0; m_hold = '0;
    m_idv = 0; m_req = 0; m_owed = 0; m_discard = 0; m_buffered = 0; m_boot = 1;
    busy = 0; cnt = 0;
  endtask

  task automatic deliver(input logic [31:0] w, input logic [31:0] pcn);
    m_instr = w; m_idpc = m_pc; m_idv = 1; m_pc = pcn; m_req = 1;
  endtask

  task automatic model_update(input bit gnt, input bit rv, input logic [31:0] rd,
                              input bit redir, input logic [31:0] pcn, input bit rdy);
    bit slot;
    bit keep;
    slot = !m_idv || rdy;
    if (m_idv && rdy) m_idv = 0;
    if (redir) begin
      keep = (m_owed && !rv) || (m_req && gnt);
      m_pc = pcn; m_idv = 0; m_hold = '0; m_buffered = 0; m_boot = 0;
      m_owed = keep; m_discard = keep; m_req = !keep;
    end else if (m_boot) begin
      m_boot = 0; m_req = 1;
    end else if (m_req) begin
      if (gnt) begin m_req = 0; m_owed = 1; m_discard = 0; end
    end else if (m_owed) begin
      if (rv) begin
        m_owed = 0;
        if (m_discard) m_req = 1;
        else if (slot) deliver(rd, pcn);
        else begin m_buffered = 1; m_hold = rd; end
      end
    end else if (m_buffered) begin
      if (slot) begin m_buffered = 0; deliver(m_hold, pcn); end
    end
  endtask

  task automatic compare_all();
    chk("imem_req", imem_req, m_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("id_valid", id_valid, m_idv);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc", id_pc, m_idpc);
  endtask

  task automatic step(input bit gnt, input bit rdy, input bit redir, input logic [31:0] tgt);
    bit          rv;
    logic [31:0] rd;
    @(negedge clk);
    compare_all();
    rv = 0;
    rd = $urandom;
    if (busy) begin
      if (cnt == 1) begin rv = 1; rd = mem_word(raddr); busy = 0; end
      else cnt--;
    end else if (spurious && $urandom_range(0, 15) == 0) begin
      rv = 1;
    end
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd; id_ready = rdy; redirect = redir;
    pc_next = redir ? tgt : m_pc + 32'd4;
    if (m_req && gnt) begin
      busy = 1; raddr = m_pc;
      cnt = (lat_fix != 0) ? lat_fix : $urandom_range(1, 4);
    end
    model_update(gnt, rv, rd, redir, pc_next, rdy);
  endtask

  task automatic release_reset(input bit rv_pulse);
    @(negedge clk);
    reset = 0; imem_gnt = 0; imem_rvalid = rv_pulse; imem_rdata = 32'hCAFE_F00D;
    redirect = 0; id_ready = 1; pc_next = m_pc + 32'd4;
    #1 compare_all();
    model_update(0, rv_pulse, imem_rdata, 0, pc_next, 1);
  endtask

  task automatic wait_owed();
    for (int i = 0; i < 12 && !m_owed; i++) step(1, 1, 0, 0);
    if (!m_owed) begin
      checks++; errors++;
      $display("FAIL wait_owed: no outstanding fetch within budget at %0t", $time);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 12 && !m_req; i++) step(1, 1, 0, 0);
    if (!m_req) begin
      checks++; errors++;
      $display("FAIL wait_req: no request within budget at %0t", $time);
    end
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, $urandom & 32'hFFFF_FFFC);
  endtask

  task automatic async_reset();
    @(negedge clk);
    compare_all();
    #2 reset = 1;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc", id_pc, 0);
    model_reset();
    imem_rvalid = 1; imem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("rst_hold_id_valid", id_valid, 0);
    release_reset(1);
  endtask

  initial begin
    model_reset();
    lat_fix = 1;
    spurious = 0;
    repeat (2) @(negedge clk);
    #1 compare_all();
    release_reset(0);

    repeat (8) step(1, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0);

    lat_fix = 2;
    wait_owed();
    step(1, 1, 1, 32'h40);
    repeat (6) step(1, 1, 0, 0);

    lat_fix = 1;
    wait_owed();
    step(1, 1, 1, 32'h80);
    repeat (4) step(1, 1, 0, 0);

    wait_req();
    repeat (3) step(0, 1, 0, 0);
    repeat (4) step(1, 1, 0, 0);

    lat_fix = 2;
    wait_owed();
    async_reset();
    repeat (4) step(1, 1, 0, 0);

    lat_fix = 0;
    spurious = 1;
    random_run(3000);
    async_reset();
    random_run(500);

    @(negedge clk);
    compare_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
